sram_controller: RTL and testbench
==================================

# sram_controller

- Sequences the MEM stage's single-cycle `mem_read`/`mem_write` requests onto an external 16-bit asynchronous SRAM.
- Each 32-bit word is transferred as two halfword accesses, each with a programmable wait time.
- While an access is in progress, `ready` is held low; the hazard/freeze logic uses it to stall every pipeline register.
- The block sits between the MEM stage and the board SRAM pins, replacing the behavioural data memory.

## Interface
Parameters:
- `WAIT_CYCLES`, 2 — cycles per halfword phase; legal range 1..15.
- `MEM_BASE`, 1024 — CPU byte address mapped to SRAM halfword 0.

Ports:
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `mem_read` in 1 — load request from MEM stage.
- `mem_write` in 1 — store request from MEM stage.
- `address` in 32 — CPU byte address.
- `wdata` in 32 — store data.
- `rdata` out 32 — load data; valid while `ready`=1 in DONE.
- `ready` out 1 — 0 = freeze pipeline.
- `sram_addr` out 18 — SRAM halfword address.
- `sram_dq_o` out 16 — write data to pad.
- `sram_dq_oe` out 1 — pad output enable.
- `sram_dq_i` in 16 — read data from pad.
- `sram_we_n` out 1 — SRAM write strobe, active-low.

## Operation
- State machine has four states: IDLE, LO, HI, DONE.
- `req = mem_read | mem_write`.
  - Both asserted is illegal from decode; if it happens, the write takes priority.
- **IDLE**
  - With `req`=1: latch `address`, `wdata`, and op (write/read), clear the wait counter, go to LO.
  - With `req`=0: stay in IDLE.
- **LO**
  - Access the low halfword (`wdata[15:0]`, or capture into `rdata[15:0]`).
  - Stay `WAIT_CYCLES` cycles, then go to HI and clear the counter.
- **HI**
  - Same as LO for the upper half (bits 31:16).
  - After `WAIT_CYCLES` cycles, go to DONE.
- **DONE**
  - Lasts one cycle, then unconditionally returns to IDLE.
  - The request still visible in DONE belongs to the completed access and is ignored.
- Address map: `offset = latched_address − MEM_BASE`, computed modulo 2^32.
  - `sram_addr = {offset[18:2], phase}`, where phase = 0 in LO and 1 in HI.
  - Bits [1:0] are ignored (word accesses only).
  - Addresses outside the SRAM wrap silently; there is no error signal.
- Writes:
  - `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of LO and HI.
  - `sram_dq_o` carries the phase's halfword.
- Reads:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `sram_dq_i` is sampled on the clock edge ending the last cycle of each phase.
- `ready = (state==IDLE && !req) || state==DONE`.
  - This is combinational, so the freeze takes effect in the same cycle the request appears.
- `rdata` holds its value until the next read completes; writes do not modify it.

## Timing
- Reset (`rst_n`=0):
  - State = IDLE, counter = 0, `rdata` = 0.
  - `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_dq_o` = 0, `sram_addr` = 0.
  - `ready` follows the IDLE equation, i.e. `~req`.
- Latency from the request cycle (cycle 0) with W = `WAIT_CYCLES`:
  - `ready`=0 on cycles 0 .. 2W.
  - DONE on cycle 2W+1, with `ready`=1 and read data valid.
  - Default W=2: 5 stall cycles, `ready` high on cycle 5.
- The earliest a back-to-back request can start is cycle 2W+2, in IDLE.
- SRAM outputs are registered or decoded from state only; there are no glitching paths from inputs to pads.
- Reset asserted mid-access aborts immediately:
  - `sram_we_n` goes high asynchronously.
  - A partial write is acceptable; the pipeline reset discards the instruction.
- Changes on `address`/`wdata` after cycle 0 have no effect on the transfer in progress.

## Structure
- Shared package `arm_pkg` holds:
  - the state enum `sram_state_t` {IDLE, LO, HI, DONE};
  - the constant `MEM_BASE_DEFAULT` = 1024.
- No sub-module is warranted.
  - The wait counter is a 4-bit register inside the controller.
  - The pad tristate is implemented at the top level from `sram_dq_o` and `sram_dq_oe`.

## Test plan
- **Write at address 1024**, `wdata`=0xDEADBEEF, W=2:
  - `sram_addr`=0 with dq 0xBEEF for 2 cycles, then `sram_addr`=1 with dq 0xDEAD for 2 cycles, `we_n` low throughout.
  - `ready` low for cycles 0–4, high on cycle 5.
- **Read at address 1028**, SRAM model holds 0x1234 at halfword 2 and 0xABCD at halfword 3:
  - `rdata`=0xABCD1234 in DONE (cycle 5).
  - `sram_dq_oe`=0 and `we_n`=1 throughout.
- **Back-to-back write then read** to the same address:
  - The read starts at cycle 6 and returns the written word.
  - `ready` high only on cycles 5 and 11.
- **No request:**
  - `ready` stays 1, `we_n`=1, no state change for 20 cycles.
- **`rst_n` pulsed low during HI of a write:**
  - `we_n` goes high the same cycle, state is IDLE, `rdata`=0.
  - A subsequent read completes normally.
- **W=1 and W=15 builds:**
  - Stall counts are 3 and 31 cycles respectively.
  - Address `MEM_BASE`−4 wraps to `sram_addr` {17'h1FFFF, phase}.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the CPU memory path: SRAM controller state encoding
// and the default CPU byte address at which external SRAM is mapped.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Moves 32-bit MEM-stage loads/stores over a 16-bit asynchronous SRAM as two
// timed halfword phases, holding ready low so the pipeline freezes meanwhile.
module sram_controller
    import arm_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_we_n
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    sram_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_write_q, is_write_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic        phase_last;
    logic        in_phase;
    logic        drive_write;
    logic [18:0] offset;
    logic        unused_bits;

    assign req        = mem_read | mem_write;
    assign phase_last = (cnt_q == LAST_CNT);

    // Only bits [18:2] of (address - MEM_BASE) reach the pads; the low two
    // bits still take part in the subtraction so any borrow is honoured.
    assign offset      = address[18:0] - MEM_BASE[18:0];
    assign unused_bits = ^{address[31:19], offset[1:0]};

    // NOTE: every variable gets a default on entry, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    word_d     = offset[18:2];
                    wdata_d    = wdata;
                    is_write_d = mem_write;
                    cnt_d      = '0;
                    state_d    = LO;
                end
            end
            LO: begin
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = HI;
                    if (!is_write_q) lo_d = sram_dq_i;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    // The full word lands at once so rdata never shows a half-updated value.
                    if (!is_write_q) rdata_d = {sram_dq_i, lo_q};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            lo_q       <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            lo_q       <= lo_d;
            rdata_q    <= rdata_d;
        end
    end

    // Pad signals decode from registered state only, so an async reset
    // releases the write strobe immediately and inputs never glitch the pins.
    assign in_phase    = (state_q == LO) || (state_q == HI);
    assign drive_write = in_phase && is_write_q;

    assign sram_addr  = in_phase ? {word_q, (state_q == HI)} : '0;
    assign sram_dq_o  = drive_write ? ((state_q == HI) ? wdata_q[31:16] : wdata_q[15:0]) : '0;
    assign sram_dq_oe = drive_write;
    assign sram_we_n  = !drive_write;

    assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: default build plus W=1 and W=15 builds
// sharing stimulus, with a small halfword SRAM model on the default build.
module tb_sram_controller;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [15:0] sram_dq_i;

    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [31:0] w1_rdata, w15_rdata;
    logic        w1_ready, w15_ready;
    logic [17:0] w1_addr, w15_addr;
    logic [15:0] w1_dq_o, w15_dq_o;
    logic        w1_oe, w15_oe;
    logic        w1_we_n, w15_we_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:63];

    sram_controller u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .rdata(w1_rdata), .ready(w1_ready),
        .sram_addr(w1_addr), .sram_dq_o(w1_dq_o), .sram_dq_oe(w1_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(w1_we_n)
    );

    sram_controller #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .rdata(w15_rdata), .ready(w15_ready),
        .sram_addr(w15_addr), .sram_dq_o(w15_dq_o), .sram_dq_oe(w15_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(w15_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_i = mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_o;
    end

    task automatic test_reset;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; wdata = '0;
        #12;
        checks++;
        if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin
            errors++;
            $display("FAIL reset_ctrl: ready/we_n/oe got %b expected 110", {ready, sram_we_n, sram_dq_oe});
        end
        checks++;
        if (sram_addr !== 18'h0 || sram_dq_o !== 16'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h dq %h rdata %h expected all zero", sram_addr, sram_dq_o, rdata);
        end
        mem_read = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_req: got %b expected 0", ready);
        end
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        logic        in_ph;
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        mem_write = 1'b1; address = 32'd1024; wdata = 32'hDEADBEEF;
        for (int c = 0; c <= 5; c++) begin
            #1;
            in_ph    = (c >= 1) && (c <= 4);
            exp_addr = in_ph ? ((c <= 2) ? 18'd0 : 18'd1) : 18'd0;
            exp_dq   = in_ph ? ((c <= 2) ? 16'hBEEF : 16'hDEAD) : 16'h0;
            checks++;
            if (ready !== (c == 5)) begin
                errors++;
                $display("FAIL write_ready c%0d: got %b expected %b", c, ready, (c == 5));
            end
            checks++;
            if (sram_addr !== exp_addr || sram_dq_o !== exp_dq || sram_we_n !== !in_ph || sram_dq_oe !== in_ph) begin
                errors++;
                $display("FAIL write_pads c%0d: addr %h dq %h we_n %b oe %b expected %h %h %b %b",
                         c, sram_addr, sram_dq_o, sram_we_n, sram_dq_oe, exp_addr, exp_dq, !in_ph, in_ph);
            end
            @(negedge clk);
            if (c == 0) begin
                mem_write = 1'b0; address = 32'h0; wdata = 32'h0;
            end
        end
    endtask

    task automatic test_read(input string tag);
        logic in_ph;
        logic [17:0] exp_addr;
        mem_read = 1'b1; address = 32'd1028;
        for (int c = 0; c <= 5; c++) begin
            #1;
            in_ph    = (c >= 1) && (c <= 4);
            exp_addr = in_ph ? ((c <= 2) ? 18'd2 : 18'd3) : 18'd0;
            checks++;
            if (ready !== (c == 5) || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s_ctrl c%0d: ready %b we_n %b oe %b addr %h expected %b 1 0 %h",
                         tag, c, ready, sram_we_n, sram_dq_oe, sram_addr, (c == 5), exp_addr);
            end
            if (c == 5) begin
                checks++;
                if (rdata !== 32'hABCD1234) begin
                    errors++;
                    $display("FAIL %s_rdata: got %h expected ABCD1234", tag, rdata);
                end
            end
            @(negedge clk);
            if (c == 0) begin
                mem_read = 1'b0; address = 32'h0;
            end
        end
    endtask

    task automatic test_back_to_back;
        mem_write = 1'b1; address = 32'd1024; wdata = 32'hCAFEF00D;
        for (int c = 0; c <= 11; c++) begin
            #1;
            checks++;
            if (ready !== (c == 5 || c == 11)) begin
                errors++;
                $display("FAIL b2b_ready c%0d: got %b expected %b", c, ready, (c == 5 || c == 11));
            end
            if (c == 5) begin
                checks++;
                if (rdata !== 32'hABCD1234) begin
                    errors++;
                    $display("FAIL b2b_rdata_hold: got %h expected ABCD1234", rdata);
                end
            end
            if (c == 11) begin
                checks++;
                if (rdata !== 32'hCAFEF00D) begin
                    errors++;
                    $display("FAIL b2b_rdata: got %h expected CAFEF00D", rdata);
                end
            end
            @(negedge clk);
            if (c == 5) begin
                mem_write = 1'b0; mem_read = 1'b1; wdata = 32'h0;
            end
            if (c == 6) begin
                mem_read = 1'b0; address = 32'h0;
            end
        end
    endtask

    task automatic test_idle;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0) begin
                errors++;
                $display("FAIL idle c%0d: ready %b we_n %b oe %b addr %h expected 1 1 0 0",
                         c, ready, sram_we_n, sram_dq_oe, sram_addr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write;
        mem_write = 1'b1; address = 32'd1024; wdata = 32'h11112222;
        @(negedge clk);
        mem_write = 1'b0; address = 32'h0; wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== 18'd1) begin
            errors++;
            $display("FAIL rst_mid_pre: we_n %b addr %h expected 0 1", sram_we_n, sram_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || ready !== 1'b1 || rdata !== 32'h0 || sram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: we_n %b ready %b rdata %h oe %b expected 1 1 0 0",
                     sram_we_n, ready, rdata, sram_dq_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wait_builds;
        int n1 = 0;
        int n15 = 0;
        repeat (40) @(negedge clk);
        mem_write = 1'b1; address = 32'd1020; wdata = 32'h5A5AA5A5;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!w1_ready) n1++;
            if (!w15_ready) n15++;
            if (c == 1) begin
                checks++;
                if (w1_addr !== 18'h3FFFE || w15_addr !== 18'h3FFFE) begin
                    errors++;
                    $display("FAIL wrap_lo: w1 %h w15 %h expected 3fffe", w1_addr, w15_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (w1_addr !== 18'h3FFFF) begin
                    errors++;
                    $display("FAIL wrap_hi_w1: got %h expected 3ffff", w1_addr);
                end
            end
            if (c == 16) begin
                checks++;
                if (w15_addr !== 18'h3FFFF) begin
                    errors++;
                    $display("FAIL wrap_hi_w15: got %h expected 3ffff", w15_addr);
                end
            end
            @(negedge clk);
            if (c == 0) begin
                mem_write = 1'b0; address = 32'h0; wdata = 32'h0;
            end
        end
        checks++;
        if (n1 != 3) begin
            errors++;
            $display("FAIL stall_w1: got %0d expected 3", n1);
        end
        checks++;
        if (n15 != 31) begin
            errors++;
            $display("FAIL stall_w15: got %0d expected 31", n15);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[2] = 16'h1234;
        mem[3] = 16'hABCD;
        test_reset();
        test_write();
        test_read("read");
        test_back_to_back();
        test_idle();
        test_reset_mid_write();
        test_read("read_after_rst");
        test_wait_builds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
